gb_clock_gen: RTL and testbench

Multi-channel programmable clock/clock-enable generator for the GBC top level, driven by the board oscillator (e.g. 33 MHz). Each channel produces a 50%-duty divided square wave and a one-cycle tick that marks each rising edge, for use as a clock enable. Divide values can be reloaded at runtime without glitches. A pause/single-step controller freezes all channels or advances them by exactly one channel-0 period, which gives the debug path a CPU single-step.

---
 rtl/gb_clock_gen.sv | 106 ++++++++++
 tb/tb_gb_clock_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gb_clock_gen.sv
// Multi-channel programmable clock / clock-enable generator with glitch-free
// divide reload and a pause / single-step controller locked to channel 0.
module gb_clock_gen #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  input  logic [CNT_W-1:0]  I_DIV_DATA,
  input  logic [NUM_CH-1:0] I_DIV_WE,
  input  logic              I_PAUSE,
  input  logic              I_STEP,
  output logic [NUM_CH-1:0] O_CLK,
  output logic [NUM_CH-1:0] O_TICK,
  output logic [1:0]        O_STATE
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_STEP_A = 2'd2,
    ST_STEP_B = 2'd3
  } state_t;

  state_t state_q, state_next;

  logic [CNT_W-1:0] cnt        [NUM_CH];
  logic [CNT_W-1:0] div_act    [NUM_CH];
  logic [CNT_W-1:0] div_shadow [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wrap;
  logic              en;

  // A programmed divide of zero behaves as one: toggle every enabled cycle.
  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  always_comb begin
    en = ((state_q == ST_RUN) && !I_PAUSE) ||
         (state_q == ST_STEP_A) || (state_q == ST_STEP_B);
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i] = en && (cnt[i] == (eff_div(div_act[i]) - CNT_W'(1)));
    end
  end

  // Channel counters, divide reload and registered clock/tick outputs
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]        <= '0;
        div_act[i]    <= CNT_W'(DEFAULT_DIV);
        div_shadow[i] <= CNT_W'(DEFAULT_DIV);
      end
      pend   <= '0;
      O_CLK  <= '0;
      O_TICK <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        O_TICK[i] <= 1'b0;
        if (I_DIV_WE[i]) begin
          div_shadow[i] <= I_DIV_DATA;
          pend[i]       <= 1'b1;
        end
        if (wrap[i]) begin
          cnt[i]    <= '0;
          O_CLK[i]  <= ~O_CLK[i];
          O_TICK[i] <= ~O_CLK[i];
          // A write landing on the wrap cycle is taken immediately.
          if (I_DIV_WE[i]) begin
            div_act[i] <= I_DIV_DATA;
          end else if (pend[i]) begin
            div_act[i] <= div_shadow[i];
          end
          pend[i] <= 1'b0;
        end else if (en) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) state_q <= ST_RUN;
    else         state_q <= state_next;
  end

  // A step lasts from entry until channel 0 has toggled twice.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_RUN:    if (I_PAUSE) state_next = ST_PAUSED;
      ST_PAUSED: begin
        if (I_STEP)        state_next = ST_STEP_A;
        else if (!I_PAUSE) state_next = ST_RUN;
      end
      ST_STEP_A: if (wrap[0]) state_next = ST_STEP_B;
      ST_STEP_B: if (wrap[0]) state_next = I_PAUSE ? ST_PAUSED : ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  assign O_STATE = state_q;

endmodule

// File: tb/tb_gb_clock_gen.sv
// Scoreboard bench for gb_clock_gen: a remaining-cycles reference model
// predicts each cycle's outputs; a monitor compares after every clock edge.
module tb_gb_clock_gen;
  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CNT_W-1:0]  div_data = '0;
  logic [NUM_CH-1:0] div_we = '0;
  logic              pause = 1'b0;
  logic              step = 1'b0;
  logic [NUM_CH-1:0] o_clk;
  logic [NUM_CH-1:0] o_tick;
  logic [1:0]        o_state;

  gb_clock_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_DIV_DATA(div_data), .I_DIV_WE(div_we),
    .I_PAUSE(pause), .I_STEP(step), .O_CLK(o_clk), .O_TICK(o_tick), .O_STATE(o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] ck;
    logic [NUM_CH-1:0] tk;
    logic [1:0]        st;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: each channel counts down the enabled cycles left in its
  // current half-period; the controller counts ch0 toggles left in a step.
  int m_lvl   [NUM_CH];
  int m_rem   [NUM_CH];
  int m_dact  [NUM_CH];
  int m_dsh   [NUM_CH];
  int m_pend  [NUM_CH];
  int m_paused;
  int m_steps;

  function automatic int deff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic cycle(input bit r, input logic [NUM_CH-1:0] w, input int d,
                       input bit p, input bit s);
    exp_t e;
    bit   en;
    bit   ch0_tog;
    rst = r; div_we = w; div_data = CNT_W'(d); pause = p; step = s;
    e.tk = '0;
    ch0_tog = 1'b0;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_lvl[i] = 0; m_dact[i] = DEFAULT_DIV; m_dsh[i] = DEFAULT_DIV;
        m_rem[i] = deff(DEFAULT_DIV); m_pend[i] = 0;
      end
      m_paused = 0; m_steps = 0;
    end else begin
      en = (m_steps > 0) || (!m_paused && !p);
      for (int i = 0; i < NUM_CH; i++) begin
        if (en && m_rem[i] == 1) begin
          m_lvl[i] = 1 - m_lvl[i];
          e.tk[i]  = (m_lvl[i] == 1);
          if (i == 0) ch0_tog = 1'b1;
          if (w[i])           m_dact[i] = d;
          else if (m_pend[i]) m_dact[i] = m_dsh[i];
          m_pend[i] = 0;
          m_rem[i]  = deff(m_dact[i]);
        end else begin
          if (en) m_rem[i]--;
          if (w[i]) m_pend[i] = 1;
        end
        if (w[i]) m_dsh[i] = d;
      end
      if (m_steps > 0) begin
        if (ch0_tog) begin
          m_steps--;
          if (m_steps == 0) m_paused = p;
        end
      end else if (!m_paused) begin
        if (p) m_paused = 1;
      end else begin
        if (s)       m_steps = 2;
        else if (!p) m_paused = 0;
      end
    end
    for (int i = 0; i < NUM_CH; i++) e.ck[i] = m_lvl[i][0];
    e.st = (m_steps == 2) ? 2'd2 : (m_steps == 1) ? 2'd3 : (m_paused ? 2'd1 : 2'd0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit p);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 0, p, 1'b0);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      total += 3;
      if (o_clk !== e.ck) begin
        bad++;
        $display("FAIL o_clk cyc=%0d actual=%b required=%b", cyc, o_clk, e.ck);
      end
      if (o_tick !== e.tk) begin
        bad++;
        $display("FAIL o_tick cyc=%0d actual=%b required=%b", cyc, o_tick, e.tk);
      end
      if (o_state !== e.st) begin
        bad++;
        $display("FAIL o_state cyc=%0d actual=%0d required=%0d", cyc, o_state, e.st);
      end
    end
  end

  initial begin
    bit p;
    // Reset release with default divide
    cycle(1'b1, '0, 0, 1'b0, 1'b0);
    cycle(1'b1, '1, 7, 1'b1, 1'b1);
    idle(16, 1'b0);
    // Reload channel 1 to 2 at cycle 1, then channel 0 to 0
    cycle(1'b1, '0, 0, 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle(1'b0, 2'b10, 2, 1'b0, 1'b0);
    idle(12, 1'b0);
    cycle(1'b0, 2'b01, 0, 1'b0, 1'b0);
    idle(12, 1'b0);
    // Pause mid half-period at cnt=2, then release
    cycle(1'b1, '0, 0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(10, 1'b1);
    idle(8, 1'b0);
    // Single step while paused, with a spurious second step in STEP_A
    idle(3, 1'b1);
    cycle(1'b0, '0, 0, 1'b1, 1'b1);
    idle(2, 1'b1);
    cycle(1'b0, '0, 0, 1'b1, 1'b1);
    idle(12, 1'b1);
    // Write while paused, then step and reset during STEP_B
    cycle(1'b0, 2'b11, 3, 1'b1, 1'b0);
    cycle(1'b0, '0, 0, 1'b1, 1'b1);
    idle(5, 1'b1);
    cycle(1'b1, '0, 0, 1'b1, 1'b0);
    idle(12, 1'b0);
    // Randomized traffic
    p = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      bit r, s;
      logic [NUM_CH-1:0] w;
      int d;
      if ($urandom_range(0, 19) == 0) p = ~p;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 7) == 0);
      w = ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom) : '0;
      d = $urandom_range(0, 5);
      cycle(r, w, d, p, s);
    end
    cycle(1'b0, '0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
